// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_ctrl_pkg;

  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] CODE_BLANK = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_t;

endpackage

// File: rtl/seg_scan_ctrl_scan_timer.sv
// Per-slot counter 0..DIV-1 with terminal flags for the blanking window and the whole slot.
module scan_timer #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16,
  parameter int CW    = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          blank_done,
  output logic          slot_done
);

  assign blank_done = (cnt == CW'(BLANK - 1));
  assign slot_done  = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (slot_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans NDIG multiplexed 7-segment digits from a double-buffered frame, with blanking,
// per-digit blink and a valid/ready frame write port.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int DIV          = 50000,
  parameter int BLANK        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [CODE_W*NDIG-1:0] wr_data,
  input  logic [NDIG-1:0]        blink_mask,
  output logic [CODE_W-1:0]      code,
  output logic [NDIG-1:0]        an,
  output logic                   frame_sync
);

  localparam int IW = $clog2(NDIG);
  localparam int CW = $clog2(DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FBITS = CODE_W * NDIG;

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [FBITS-1:0]  active, active_n;
  logic [FBITS-1:0]  pending, pending_n;
  logic              pfull, pfull_n;
  logic              phase, phase_n;
  logic [FW-1:0]     fcnt, fcnt_n;
  logic [NDIG-1:0]   an_n;
  logic [CODE_W-1:0] code_n;
  logic              fs_n;

  logic [CW-1:0] cnt;
  logic          blank_done, slot_done;
  logic          clr, boundary, accept;

  assign clr      = (state == ST_IDLE) || !en;
  assign boundary = (state == ST_DRIVE) && slot_done && (idx == IW'(NDIG - 1));
  assign accept   = wr_valid && wr_ready;

  scan_timer #(
    .DIV   (DIV),
    .BLANK (BLANK),
    .CW    (CW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .cnt        (cnt),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    active_n  = active;
    pending_n = pending;
    pfull_n   = pfull;
    phase_n   = phase;
    fcnt_n    = fcnt;

    if (!en) begin
      state_n = ST_IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_BLANK;
          idx_n   = '0;
        end
        ST_BLANK: if (blank_done) state_n = ST_DRIVE;
        ST_DRIVE: if (slot_done) begin
          state_n = ST_BLANK;
          idx_n   = (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
        end
        default: state_n = ST_IDLE;
      endcase
    end

    // A write landing on the boundary with nothing pending bypasses the pending buffer
    if ((boundary || state == ST_IDLE) && pfull) begin
      active_n = pending;
      pfull_n  = 1'b0;
    end else if (boundary && accept) begin
      active_n = wr_data;
    end else if (accept) begin
      pending_n = wr_data;
      pfull_n   = 1'b1;
    end

    if (boundary) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt_n  = '0;
        phase_n = !phase;
      end else begin
        fcnt_n = fcnt + FW'(1);
      end
    end

    // Outputs are registered, so they are derived from the next-state values
    an_n = '1;
    if (state_n == ST_DRIVE && !(blink_mask[idx_n] && phase_n)) an_n[idx_n] = 1'b0;
    code_n = (state_n == ST_IDLE) ? CODE_BLANK : active_n[idx_n*CODE_W +: CODE_W];
    fs_n   = (state_n == ST_DRIVE) && (idx_n == IW'(NDIG - 1)) && !clr
             && (cnt == CW'(DIV - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      active     <= {NDIG{CODE_BLANK}};
      pending    <= {NDIG{CODE_BLANK}};
      pfull      <= 1'b0;
      wr_ready   <= 1'b1;
      phase      <= 1'b0;
      fcnt       <= '0;
      an         <= '1;
      code       <= CODE_BLANK;
      frame_sync <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      active     <= active_n;
      pending    <= pending_n;
      pfull      <= pfull_n;
      wr_ready   <= !pfull_n;
      phase      <= phase_n;
      fcnt       <= fcnt_n;
      an         <= an_n;
      code       <= code_n;
      frame_sync <= fs_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=4, DIV=8, BLANK=2, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, wr_valid;
  logic        wr_ready;
  logic [19:0] wr_data;
  logic [3:0]  blink_mask;
  logic [4:0]  code;
  logic [3:0]  an;
  logic        frame_sync;

  int checks   = 0;
  int failures = 0;
  int frame_no = 1;

  logic [19:0] f1, f9, f4, f5, f6, fb;

  seg_scan_ctrl #(
    .NDIG         (4),
    .DIV          (8),
    .BLANK        (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .blink_mask (blink_mask),
    .code       (code),
    .an         (an),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Checks one 32-cycle frame starting at cycle 0 (first BLANK cycle of digit 0).
  // wr_at: cycle during which wr_valid is offered (-1 none); stop_at: return after checking that cycle.
  task automatic scan_frame(input logic [19:0] codes, input logic [3:0] dark,
                            input int wr_at, input logic [19:0] wdata, input int stop_at);
    for (int k = 0; k < 32; k++) begin
      int d;
      int pos;
      logic [3:0] exp_an;
      d   = k / 8;
      pos = k % 8;
      exp_an = 4'hF;
      if (pos >= 2 && !dark[d]) exp_an[d] = 1'b0;
      chk($sformatf("an f%0d k%0d", frame_no, k), an, exp_an);
      chk($sformatf("code f%0d k%0d", frame_no, k), code, codes[d*5 +: 5]);
      chk($sformatf("frame_sync f%0d k%0d", frame_no, k), frame_sync, (k == 31));
      chk($sformatf("wr_ready f%0d k%0d", frame_no, k), wr_ready,
          (wr_at >= 0 && k > wr_at) ? 1'b0 : 1'b1);
      if (k == stop_at) begin
        wr_valid = 1'b0;
        frame_no++;
        return;
      end
      wr_valid = (k == wr_at);
      wr_data  = (k == wr_at) ? wdata : 20'($urandom);
      tick();
    end
    frame_no++;
  endtask

  initial begin
    f1 = {5'd3, 5'd2, 5'd1, 5'd0};
    f9 = {4{5'd9}};
    f4 = {5'd4, 5'd5, 5'd6, 5'd7};
    f5 = {5'd12, 5'd17, 5'd22, 5'd27};
    f6 = {4{5'd30}};
    fb = {4{5'd31}};

    rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0; blink_mask = '0;
    tick(); tick();
    chk("rst an", an, 4'hF);
    chk("rst code", code, 5'd31);
    chk("rst wr_ready", wr_ready, 1'b1);
    chk("rst frame_sync", frame_sync, 1'b0);

    // Frame loaded while idle, then scanning enabled
    rst = 1'b0; wr_valid = 1'b1; wr_data = f1;
    tick();
    chk("idle accept wr_ready", wr_ready, 1'b0);
    wr_valid = 1'b0;
    tick();
    chk("idle copy wr_ready", wr_ready, 1'b1);
    en = 1'b1;
    tick();
    scan_frame(f1, 4'b0000, -1, '0, -1);

    // Mid-frame write at digit 1, shown from the next frame
    scan_frame(f1, 4'b0000, 10, f9, -1);

    // Blink on digit 0 (phase 1 for frames 3-4); write on the exact boundary cycle
    blink_mask = 4'b0001;
    scan_frame(f9, 4'b0001, 31, f4, -1);
    scan_frame(f4, 4'b0001, -1, '0, -1);
    scan_frame(f4, 4'b0000, -1, '0, -1);
    scan_frame(f4, 4'b0000, -1, '0, -1);
    blink_mask = 4'b0000;

    // Disable during digit 2 DRIVE, write while idle, re-enable
    scan_frame(f4, 4'b0000, -1, '0, 20);
    en = 1'b0;
    tick();
    chk("en off an", an, 4'hF);
    chk("en off frame_sync", frame_sync, 1'b0);
    chk("en off wr_ready", wr_ready, 1'b1);
    wr_valid = 1'b1; wr_data = f5;
    tick();
    chk("idle2 accept wr_ready", wr_ready, 1'b0);
    chk("idle2 an", an, 4'hF);
    wr_valid = 1'b0;
    tick();
    chk("idle2 copy wr_ready", wr_ready, 1'b1);
    en = 1'b1;
    tick();
    scan_frame(f5, 4'b0000, -1, '0, -1);

    // Reset mid-frame with a pending frame held
    scan_frame(f5, 4'b0000, 3, f6, 12);
    rst = 1'b1;
    tick();
    chk("rst2 an", an, 4'hF);
    chk("rst2 code", code, 5'd31);
    chk("rst2 wr_ready", wr_ready, 1'b1);
    chk("rst2 frame_sync", frame_sync, 1'b0);
    rst = 1'b0;
    tick();
    scan_frame(fb, 4'b0000, -1, '0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
